// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// Optional checksum stage is controlled by IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

    localparam int LEN_W          = 16;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_e;

    function automatic logic can_start(input state_e s);
        return (s == IDLE) || (s == DONE) || (s == ERR);
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a byte stream into little-endian 32-bit words; flags the fourth byte.
// The word is presented combinationally alongside word_valid_o.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        areset_i,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  lane_q;
    logic [23:0] shift_q;

    // Earlier bytes shift down so byte 0 ends up in [7:0] when byte 3 arrives.
    always_ff @(posedge clk_i) begin
        if (areset_i || clear_i) begin
            lane_q  <= 2'd0;
            shift_q <= 24'd0;
        end else if (byte_valid_i) begin
            lane_q  <= lane_q + 2'd1;
            shift_q <= {byte_i, shift_q[23:8]};
        end
    end

    assign word_valid_o = byte_valid_i && (lane_q == 2'(BYTES_PER_WORD - 1));
    assign word_o       = {byte_i, shift_q};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length header, LE word packing, sequential imem writes, core hold.
// With IMEM_LOADER_CHECKSUM_EN defined, a trailing XOR checksum byte is verified.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              areset_i,
    input  logic              start_i,
    input  logic [7:0]        in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_waddr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              core_hold_o,
    output logic              done_o,
    output logic              error_o
);

    localparam int unsigned CAP = 32'd1 << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e AFTER_DATA = CSUM;
`else
    localparam state_e AFTER_DATA = DONE;
`endif

    state_e              state_q;
    logic                in_ready_q;
    logic                imem_we_q;
    logic [ADDR_W-1:0]   imem_waddr_q;
    logic [31:0]         imem_wdata_q;
    logic                core_hold_q;
    logic                done_q;
    logic                error_q;
    logic [7:0]          len_lo_q;
    logic [LEN_W-1:0]    n_q;
    logic [ADDR_W-1:0]   cnt_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          csum_q;
`endif

    logic                accept;
    logic                data_accept;
    logic                restart;
    logic                word_valid;
    logic [31:0]         word;
    logic [LEN_W-1:0]    len_d;
    logic                last_word;

    assign accept      = in_valid_i && in_ready_q;
    assign data_accept = accept && (state_q == DATA);
    assign restart     = start_i && can_start(state_q);
    assign len_d       = {in_data_i, len_lo_q};
    assign last_word   = (LEN_W'(cnt_q) == (n_q - LEN_W'(1)));

    imem_loader_byte_packer u_packer (
        .clk_i        (clk_i),
        .areset_i     (areset_i),
        .clear_i      (restart),
        .byte_valid_i (data_accept),
        .byte_i       (in_data_i),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_ff @(posedge clk_i) begin
        if (areset_i) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_waddr_q <= '0;
            imem_wdata_q <= '0;
            core_hold_q  <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            len_lo_q     <= '0;
            n_q          <= '0;
            cnt_q        <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            imem_we_q <= 1'b0;
            if (word_valid) begin
                imem_we_q    <= 1'b1;
                imem_waddr_q <= cnt_q;
                imem_wdata_q <= word;
                cnt_q        <= cnt_q + ADDR_W'(1);
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (data_accept) begin
                csum_q <= csum_q ^ in_data_i;
            end
`endif
            case (state_q)
                IDLE, DONE, ERR: begin
                    // Core is released one cycle after DONE is entered, i.e. after the final write.
                    if (state_q == DONE) begin
                        done_q      <= 1'b1;
                        core_hold_q <= 1'b0;
                    end
                    if (start_i) begin
                        state_q     <= LEN0;
                        in_ready_q  <= 1'b1;
                        done_q      <= 1'b0;
                        error_q     <= 1'b0;
                        core_hold_q <= 1'b1;
                        cnt_q       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_q      <= '0;
`endif
                    end
                end
                LEN0: begin
                    if (accept) begin
                        len_lo_q <= in_data_i;
                        state_q  <= LEN1;
                    end
                end
                LEN1: begin
                    if (accept) begin
                        n_q <= len_d;
                        if (len_d == '0) begin
                            state_q    <= AFTER_DATA;
                            in_ready_q <= (AFTER_DATA == CSUM);
                        end else if (32'(len_d) > CAP) begin
                            state_q    <= ERR;
                            in_ready_q <= 1'b0;
                            error_q    <= 1'b1;
                        end else begin
                            state_q <= DATA;
                            cnt_q   <= '0;
                        end
                    end
                end
                DATA: begin
                    if (word_valid && last_word) begin
                        state_q    <= AFTER_DATA;
                        in_ready_q <= (AFTER_DATA == CSUM);
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CSUM: begin
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        if (in_data_i == csum_q) begin
                            state_q     <= DONE;
                            done_q      <= 1'b1;
                            core_hold_q <= 1'b0;
                        end else begin
                            state_q <= ERR;
                            error_q <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o   = in_ready_q;
    assign imem_we_o    = imem_we_q;
    assign imem_waddr_o = imem_waddr_q;
    assign imem_wdata_o = imem_wdata_q;
    assign core_hold_o  = core_hold_q;
    assign done_o       = done_q;
    assign error_o      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: scoreboard of expected writes plus per-scenario checks.
module tb_imem_loader;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              areset = 1'b1;
    logic              start = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              core_hold;
    logic              done;
    logic              error;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk_i        (clk),
        .areset_i     (areset),
        .start_i      (start),
        .in_data_i    (in_data),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .imem_we_o    (imem_we),
        .imem_waddr_o (imem_waddr),
        .imem_wdata_o (imem_wdata),
        .core_hold_o  (core_hold),
        .done_o       (done),
        .error_o      (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t               exp_q[$];
    wr_t               mon_e;
    int                cyc = 0;
    int                n_checks = 0;
    int                n_fail = 0;
    int                n_writes = 0;
    int                last_we_cyc = -1;
    int                stall_max = 0;
    logic              we_prev = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [7:0]        csum_acc = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: every strobe must match the head of the scoreboard and be one cycle wide.
    always @(negedge clk) begin
        if (imem_we) begin
            n_writes++;
            last_we_cyc = cyc;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL write_unexpected: got addr=%0h data=%h, required no write", imem_waddr, imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if ({imem_waddr, imem_wdata} !== {mon_e.addr, mon_e.data}) begin
                    n_fail++;
                    $display("FAIL write_value: got addr=%0h data=%h, required addr=%0h data=%h",
                             imem_waddr, imem_wdata, mon_e.addr, mon_e.data);
                end
            end
            n_checks++;
            if (we_prev) begin
                n_fail++;
                $display("FAIL we_width: got strobe on consecutive cycles, required one-cycle strobe");
            end
        end
        we_prev = imem_we;
    end

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        repeat ($urandom_range(stall_max, 0)) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL byte_timeout: in_ready=%0b after 100 cycles, required 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        exp_q.push_back('{addr: wr_addr, data: w});
        wr_addr++;
        for (int i = 0; i < 4; i++) begin
            csum_acc ^= w[8*i +: 8];
            send_byte(w[8*i +: 8]);
        end
    endtask

    task automatic pulse_start();
        wr_addr  = '0;
        csum_acc = 8'h00;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_header(input logic [15:0] n);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
    endtask

    task automatic send_csum();
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(csum_acc);
`endif
    endtask

    task automatic wait_done(output int dcyc);
        dcyc = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done) begin
                dcyc = cyc;
                break;
            end
        end
        n_checks++;
        if (dcyc < 0) begin
            n_fail++;
            $display("FAIL done_timeout: done=%0b after 200 cycles, required 1", done);
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(negedge clk);
        areset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({core_hold, done, error, in_ready, imem_we} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_flags: got hold/done/err/rdy/we=%b, required 10000",
                     {core_hold, done, error, in_ready, imem_we});
        end
        n_checks++;
        if ({imem_waddr, imem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_bus: got addr=%0h data=%h, required 0", imem_waddr, imem_wdata);
        end
        repeat (20) @(negedge clk);
        n_checks++;
        if ({core_hold, in_ready, done} !== 3'b100) begin
            n_fail++;
            $display("FAIL idle_hold: got hold/rdy/done=%b, required 100", {core_hold, in_ready, done});
        end
    endtask

    task automatic test_load_n2();
        int w0 = n_writes;
        int dc;
        pulse_start();
        send_header(16'd2);
        send_word(32'h12345678);
        send_word(32'hDEADBEEF);
        send_csum();
        wait_done(dc);
`ifndef IMEM_LOADER_CHECKSUM_EN
        n_checks++;
        if (dc != last_we_cyc + 1) begin
            n_fail++;
            $display("FAIL n2_done_timing: got done at cycle %0d, required %0d", dc, last_we_cyc + 1);
        end
`endif
        n_checks++;
        if ({core_hold, error, in_ready} !== 3'b000) begin
            n_fail++;
            $display("FAIL n2_flags: got hold/err/rdy=%b, required 000", {core_hold, error, in_ready});
        end
        n_checks++;
        if (n_writes - w0 != 2 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL n2_writes: got %0d writes (%0d pending), required 2 (0)", n_writes - w0, exp_q.size());
        end
    endtask

    task automatic test_oversize();
        int w0 = n_writes;
        int dc;
        pulse_start();
        send_header(16'h0101);
        repeat (5) @(negedge clk);
        n_checks++;
        if ({error, core_hold, in_ready, done} !== 4'b1100) begin
            n_fail++;
            $display("FAIL oversize_flags: got err/hold/rdy/done=%b, required 1100",
                     {error, core_hold, in_ready, done});
        end
        n_checks++;
        if (n_writes != w0) begin
            n_fail++;
            $display("FAIL oversize_writes: got %0d writes, required 0", n_writes - w0);
        end
        pulse_start();
        n_checks++;
        if ({error, in_ready, core_hold} !== 3'b011) begin
            n_fail++;
            $display("FAIL err_restart: got err/rdy/hold=%b, required 011", {error, in_ready, core_hold});
        end
        send_header(16'd1);
        send_word(32'hCAFEF00D);
        send_csum();
        wait_done(dc);
        n_checks++;
        if (n_writes - w0 != 1 || error !== 1'b0 || core_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL err_reload: got writes=%0d err=%b hold=%b, required 1 0 0", n_writes - w0, error, core_hold);
        end
    endtask

    task automatic test_capacity();
        int w0 = n_writes;
        int dc;
        pulse_start();
        send_header(16'd256);
        for (int i = 0; i < 256; i++) send_word($urandom);
        send_csum();
        wait_done(dc);
        n_checks++;
        if (n_writes - w0 != 256 || error !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL capacity: got writes=%0d err=%b pending=%0d, required 256 0 0",
                     n_writes - w0, error, exp_q.size());
        end
    endtask

    task automatic test_stall_reset();
        int w0 = n_writes;
        int dc;
        stall_max = 3;
        pulse_start();
        send_header(16'd3);
        for (int i = 0; i < 3; i++) send_word($urandom);
        send_csum();
        wait_done(dc);
        stall_max = 0;
        n_checks++;
        if (n_writes - w0 != 3 || core_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_load: got writes=%0d hold=%b, required 3 0", n_writes - w0, core_hold);
        end
        w0 = n_writes;
        pulse_start();
        send_header(16'd3);
        send_word(32'hA5A55A5A);
        repeat (3) @(negedge clk);
        areset = 1'b1;
        repeat (2) @(negedge clk);
        areset = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++;
        if (n_writes - w0 != 1) begin
            n_fail++;
            $display("FAIL reset_abort_writes: got %0d writes, required 1", n_writes - w0);
        end
        n_checks++;
        if ({core_hold, in_ready, done, error} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_abort_flags: got hold/rdy/done/err=%b, required 1000",
                     {core_hold, in_ready, done, error});
        end
        w0 = n_writes;
        pulse_start();
        send_header(16'd2);
        send_word(32'h0BADF00D);
        send_word(32'h600DCAFE);
        send_csum();
        wait_done(dc);
        n_checks++;
        if (n_writes - w0 != 2 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_reload: got writes=%0d pending=%0d, required 2 0", n_writes - w0, exp_q.size());
        end
    endtask

    task automatic test_n0_restart();
        int w0 = n_writes;
        int dc;
        pulse_start();
        send_header(16'd0);
        send_csum();
        wait_done(dc);
        n_checks++;
        if (n_writes != w0 || core_hold !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL n0_done: got writes=%0d hold=%b rdy=%b, required 0 0 0", n_writes - w0, core_hold, in_ready);
        end
        wr_addr  = '0;
        csum_acc = 8'h00;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if ({core_hold, done, in_ready} !== 3'b101) begin
            n_fail++;
            $display("FAIL done_restart: got hold/done/rdy=%b, required 101", {core_hold, done, in_ready});
        end
        send_header(16'd1);
        send_word(32'h13579BDF);
        send_csum();
        wait_done(dc);
        n_checks++;
        if (n_writes - w0 != 1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL n0_reload: got writes=%0d pending=%0d, required 1 0", n_writes - w0, exp_q.size());
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int w0 = n_writes;
        int dc;
        pulse_start();
        send_header(16'd1);
        send_word(32'h08040201);
        send_byte(8'h0F);
        wait_done(dc);
        n_checks++;
        if (error !== 1'b0 || core_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL csum_match: got err=%b hold=%b, required 0 0", error, core_hold);
        end
        w0 = n_writes;
        pulse_start();
        send_header(16'd1);
        send_word(32'h08040201);
        send_byte(8'h0E);
        repeat (3) @(negedge clk);
        n_checks++;
        if ({error, done, core_hold} !== 3'b101 || n_writes - w0 != 1) begin
            n_fail++;
            $display("FAIL csum_mismatch: got err/done/hold=%b writes=%0d, required 101 1",
                     {error, done, core_hold}, n_writes - w0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_n2();
        test_oversize();
        test_capacity();
        test_stall_reset();
        test_n0_restart();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at 2 ms, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader that sits directly upstream of the single-cycle core's instruction memory.
- Accepts a byte stream over a valid/ready handshake from a host link, such as a UART RX or a debug bridge.
- Assembles the bytes into little-endian 32-bit words and writes them sequentially into instruction memory from word address 0.
- Holds the core's PC load disabled (core_hold) until a complete image has been written.

Parameters:
- ADDR_W, 8: instruction-memory word-address width; capacity 2^ADDR_W words.
- LEN_W, 16: width of the image word-count header; fixed at 16, not user-overridable.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- areset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE and ERR.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader can accept a byte.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_waddr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  word to write.
- core_hold  out  1  high = core PC load suppressed (gates pc register load).
- done  out  1  image loaded successfully; level.
- error  out  1  load aborted; level.

Behaviour:
- Reset values: in_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, core_hold=1, done=0, error=0, state=IDLE.
- Reset mid-load: abandons the load immediately; no further writes.
- Byte acceptance: a byte is accepted on a cycle where in_valid && in_ready. in_ready is a registered function of state only: high in LEN0, LEN1, DATA, CSUM; low elsewhere.
- States and transitions:
  - IDLE: core_hold=1. start -> LEN0.
  - LEN0: accept low byte of word count N.
  - LEN1: accept high byte of N. Then:
    - N == 0 -> DONE.
    - N > 2^ADDR_W -> ERR; no writes issued.
    - otherwise -> DATA, word counter=0, byte index=0.
  - DATA: bytes pack little-endian; byte 0 -> [7:0], byte 3 -> [31:24].
    - When byte 3 is accepted at cycle t, imem_we=1 at t+1 with imem_waddr=counter and imem_wdata=the packed word; the counter then increments.
    - imem_we is strictly one cycle wide; back-to-back words may produce strobes 4 cycles apart minimum.
    - When the last word (counter == N-1) is accepted at t: write at t+1; state reaches DONE (or CSUM) at t+1.
  - DONE: done=1 and core_hold=0, both from t+2, i.e. one cycle after the final write. in_ready=0. start -> LEN0 with core_hold=1 and done=0 next cycle.
  - ERR: error=1, core_hold=1, in_ready=0. Exit only via start (-> LEN0, error cleared) or reset.
- start while in LEN0/LEN1/DATA/CSUM is ignored.
- The host may pause in_valid at any point; no timeout.
- Address wrap cannot occur: N is bounded against capacity in LEN1.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined: after the last data byte the state goes to CSUM (not DONE) and accepts one byte = XOR of all 4N payload bytes.
  - Checksum accepted at t: match -> DONE with done=1, core_hold=0 at t+1; mismatch -> ERR at t+1.
  - Words already written are left in memory.
  - N == 0 still expects the checksum byte, value 0x00.
- Undefined: no CSUM state and no checksum logic; timing as above.

Decomposition:
- Package imem_loader_pkg:
  - state enum: IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR.
  - LEN_W = 16.
  - byte-lane constants BYTES_PER_WORD = 4.
- One natural sub-module, byte_packer: a 2-bit lane index plus a 32-bit shift/insert register. It outputs word_valid on the 4th byte and clears on areset or on the top-level restart.

Test Plan:
- Reset release: after areset, core_hold=1, done=0, error=0, in_ready=0; holds indefinitely without start.
- Load, N=2: bytes 02 00 | 78 56 34 12 | EF BE AD DE produce:
  - writes addr0=0x12345678, addr1=0xDEADBEEF, one cycle each;
  - done=1 and core_hold=0 one cycle after the second write.
- Oversize: ADDR_W=8, header 01 01 (N=257) -> ERR, error=1, zero imem_we pulses, core_hold=1. Then start plus a valid image -> error clears, load succeeds.
- Stall and reset: random in_valid gaps produce an identical write sequence. areset asserted after word 0 gives no further writes and returns to IDLE; start after reset reloads from addr 0.
- N=0 and restart: header 00 00 -> DONE with no writes. start in DONE raises core_hold in the next cycle.
- IMEM_LOADER_CHECKSUM_EN: N=1 with data 01 02 04 08 plus checksum 0x0F -> DONE. The same stream with checksum 0x0E -> ERR after the word write at addr0.
